// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: constant clog2 and the FWFT mode selectors used by all FIFO variants.
package fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping storage pointer: advances on inc and returns to 0 after DEPTH-1.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (r_ptr == PW'(DEPTH - 1)) r_ptr <= '0;
      else                         r_ptr <= r_ptr + PW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with any depth >= 2, selectable registered-read or first-word-fall-through
// output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned FWFT      = FWFT_OFF,
  parameter  int unsigned AFULL_TH  = DEPTH - 1,
  parameter  int unsigned AEMPTY_TH = 1,
  localparam int unsigned CW        = clog2(DEPTH + 1),
  localparam int unsigned PW        = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_wr,
  input  logic             en_rd,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2) begin : g_chk_depth
    $error("fifo_flex: DEPTH must be at least 2");
  end
  if (AFULL_TH > DEPTH) begin : g_chk_afull
    $error("fifo_flex: AFULL_TH must not exceed DEPTH");
  end
  if (AEMPTY_TH >= DEPTH) begin : g_chk_aempty
    $error("fifo_flex: AEMPTY_TH must be below DEPTH");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [PW-1:0]    w_ptr_wr;
  logic [PW-1:0]    w_ptr_rd;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_rd_ok = en_rd & ~w_empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_wr_ok = en_wr & (~w_full | w_rd_ok);

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr_wr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wr_ok),
    .ptr   (w_ptr_wr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr_rd (
    .clk   (clk),
    .reset (reset),
    .inc   (w_rd_ok),
    .ptr   (w_ptr_rd)
  );

  // Storage is intentionally not reset; occupancy gating hides stale words.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_ptr_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      r_overflow  <= (en_wr & ~w_wr_ok) | (r_overflow & ~clr_err);
      r_underflow <= (en_rd & w_empty) | (r_underflow & ~clr_err);
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so stale storage never leaks.
    assign dout     = w_empty ? '0 : r_mem[w_ptr_rd];
    assign rd_valid = ~w_empty;
  end else begin : g_regrd
    logic [WIDTH-1:0] r_dout;
    logic             r_rd_valid;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_dout     <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_ok;
        if (w_rd_ok) r_dout <= r_mem[w_ptr_rd];
      end
    end

    assign dout     = r_dout;
    assign rd_valid = r_rd_valid;
  end

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (32'(r_count) <= AEMPTY_TH);
  assign almost_full  = (32'(r_count) >= AFULL_TH);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read DEPTH=5 instance and a FWFT DEPTH=8 instance with
// custom thresholds, checked by directed scenarios and a queue-based reference model.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       en_wr0 = 1'b0, en_rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = 8'd0;
  logic [7:0] dout0;
  logic       rv0, empty0, full0, ae0, af0, ovf0, udf0;
  logic [2:0] count0;

  logic       en_wr1 = 1'b0, en_rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = 8'd0;
  logic [7:0] dout1;
  logic       rv1, empty1, full1, ae1, af1, ovf1, udf1;
  logic [3:0] count1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_dout0;
  logic       m_rv0, m_ovf0, m_udf0, m_ovf1, m_udf1;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .en_wr(en_wr0), .en_rd(en_rd0), .din(din0), .clr_err(clr0),
    .dout(dout0), .rd_valid(rv0), .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut1 (
    .clk(clk), .reset(reset), .en_wr(en_wr1), .en_rd(en_rd1), .din(din1), .clr_err(clr1),
    .dout(dout1), .rd_valid(rv1), .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic idle();
    en_wr0 = 1'b0; en_rd0 = 1'b0; clr0 = 1'b0;
    en_wr1 = 1'b0; en_rd1 = 1'b0; clr1 = 1'b0;
  endtask

  // Advance the reference model with the current inputs, then clock the DUTs.
  task automatic tick();
    bit rd, wr;
    if (reset) begin
      q0.delete(); q1.delete();
      m_dout0 = 8'd0; m_rv0 = 1'b0;
      m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
    end else begin
      rd = en_rd0 && q0.size() > 0;
      wr = en_wr0 && (q0.size() < 5 || rd);
      m_ovf0 = (en_wr0 && !wr) || (m_ovf0 && !clr0);
      m_udf0 = (en_rd0 && q0.size() == 0) || (m_udf0 && !clr0);
      m_rv0  = rd;
      if (rd) m_dout0 = q0.pop_front();
      if (wr) q0.push_back(din0);

      rd = en_rd1 && q1.size() > 0;
      wr = en_wr1 && (q1.size() < 8 || rd);
      m_ovf1 = (en_wr1 && !wr) || (m_ovf1 && !clr1);
      m_udf1 = (en_rd1 && q1.size() == 0) || (m_udf1 && !clr1);
      if (rd) void'(q1.pop_front());
      if (wr) q1.push_back(din1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    n_tests++;
    if ({count0, empty0, full0, ae0, af0, rv0, ovf0, udf0, dout0} !== {3'd0, 7'b1010000, 8'd0}) begin
      n_fail++;
      $display("FAIL reset0 act=%h exp=%h", {count0, empty0, full0, ae0, af0, rv0, ovf0, udf0, dout0},
               {3'd0, 7'b1010000, 8'd0});
    end
    n_tests++;
    if ({count1, empty1, full1, ae1, af1, rv1, ovf1, udf1, dout1} !== {4'd0, 7'b1010000, 8'd0}) begin
      n_fail++;
      $display("FAIL reset1 act=%h exp=%h", {count1, empty1, full1, ae1, af1, rv1, ovf1, udf1, dout1},
               {4'd0, 7'b1010000, 8'd0});
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_overflow();
    idle();
    for (int i = 1; i <= 5; i++) begin
      en_wr0 = 1'b1; din0 = 8'(i);
      tick();
    end
    n_tests++;
    if ({full0, count0} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL fill_full act=%b/%0d exp=1/5", full0, count0);
    end
    din0 = 8'h99;
    tick();
    en_wr0 = 1'b0;
    n_tests++;
    if ({ovf0, count0} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL overflow_set act=%b/%0d exp=1/5", ovf0, count0);
    end
    for (int i = 1; i <= 5; i++) begin
      en_rd0 = 1'b1;
      tick();
      n_tests++;
      if ({rv0, dout0} !== {1'b1, 8'(i)}) begin
        n_fail++; $display("FAIL read_order act=%b/%0d exp=1/%0d", rv0, dout0, i);
      end
    end
    en_rd0 = 1'b0; clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    n_tests++;
    if ({rv0, empty0, ovf0, dout0} !== {1'b0, 1'b1, 1'b0, 8'd5}) begin
      n_fail++; $display("FAIL after_drain act=%b%b%b/%0d exp=010/5", rv0, empty0, ovf0, dout0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    idle();
    en_wr0 = 1'b1;
    din0 = 8'd10; tick();
    din0 = 8'd11; tick();
    en_rd0 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      en_wr0 = (k < 12);
      din0   = 8'(20 + k);
      exp    = (k < 2) ? 8'(10 + k) : 8'(20 + k - 2);
      tick();
      n_tests++;
      if ({rv0, dout0} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL wrap_data k=%0d act=%b/%0d exp=1/%0d", k, rv0, dout0, exp);
      end
      if (k < 12) begin
        n_tests++;
        if (count0 !== 3'd2) begin
          n_fail++; $display("FAIL wrap_count k=%0d act=%0d exp=2", k, count0);
        end
      end
    end
    idle(); tick();
  endtask

  task automatic test_full_simul();
    logic [7:0] exp;
    idle();
    en_wr0 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din0 = 8'(40 + i); tick();
    end
    en_rd0 = 1'b1; din0 = 8'hAA;
    tick();
    n_tests++;
    if ({dout0, count0, ovf0, full0} !== {8'd41, 3'd5, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL full_simul act=%0d/%0d/%b/%b exp=41/5/0/1", dout0, count0, ovf0, full0);
    end
    en_wr0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = (i < 4) ? 8'(42 + i) : 8'hAA;
      tick();
      n_tests++;
      if (dout0 !== exp) begin
        n_fail++; $display("FAIL full_simul_drain i=%0d act=%h exp=%h", i, dout0, exp);
      end
    end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    idle();
    en_wr0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      din0 = 8'(60 + i); tick();
    end
    en_wr0 = 1'b0; en_rd0 = 1'b1;
    tick();
    en_rd0 = 1'b0;
    n_tests++;
    if ({count0, ovf0, dout0} !== {3'd4, 1'b1, 8'd61}) begin
      n_fail++; $display("FAIL pre_reset act=%0d/%b/%0d exp=4/1/61", count0, ovf0, dout0);
    end
    reset = 1'b1; en_wr0 = 1'b1; din0 = 8'h77;
    tick();
    reset = 1'b0; en_wr0 = 1'b0;
    n_tests++;
    if ({count0, empty0, ae0, rv0, ovf0, udf0, dout0} !== {3'd0, 5'b11000, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid act=%0d/%b%b%b%b%b/%h exp=0/11000/00", count0, empty0, ae0, rv0, ovf0, udf0, dout0);
    end
    en_rd0 = 1'b1;
    tick();
    en_rd0 = 1'b0;
    n_tests++;
    if ({count0, rv0, udf0} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_discard act=%0d/%b/%b exp=0/0/1", count0, rv0, udf0);
    end
  endtask

  task automatic test_fwft();
    idle();
    en_wr1 = 1'b1; din1 = 8'h3C;
    tick();
    en_wr1 = 1'b0;
    n_tests++;
    if ({dout1, empty1, rv1} !== {8'h3C, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fwft_fall act=%h/%b/%b exp=3c/0/1", dout1, empty1, rv1);
    end
    en_rd1 = 1'b1;
    tick();
    n_tests++;
    if ({empty1, udf1} !== 2'b10) begin
      n_fail++; $display("FAIL fwft_pop act=%b%b exp=10", empty1, udf1);
    end
    tick();
    en_rd1 = 1'b0;
    n_tests++;
    if (udf1 !== 1'b1) begin
      n_fail++; $display("FAIL fwft_underflow act=%b exp=1", udf1);
    end
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    n_tests++;
    if (udf1 !== 1'b0) begin
      n_fail++; $display("FAIL fwft_clr act=%b exp=0", udf1);
    end
    en_wr1 = 1'b1; en_rd1 = 1'b1; din1 = 8'h5A;
    tick();
    n_tests++;
    if ({count1, udf1, dout1} !== {4'd1, 1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL empty_simul act=%0d/%b/%h exp=1/1/5a", count1, udf1, dout1);
    end
    en_wr1 = 1'b0; clr1 = 1'b1;
    tick();
    idle();
    n_tests++;
    if ({count1, udf1} !== {4'd0, 1'b0}) begin
      n_fail++; $display("FAIL empty_simul_drain act=%0d/%b exp=0/0", count1, udf1);
    end
  endtask

  task automatic test_thresholds();
    idle();
    en_wr1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din1 = 8'(k); tick();
      n_tests++;
      if ({count1, af1, ae1, full1} !== {4'(k), k >= 6, k <= 2, k == 8}) begin
        n_fail++;
        $display("FAIL thr_fill k=%0d act=%0d/%b%b%b exp=%0d/%b%b%b", k, count1, af1, ae1, full1,
                 k, k >= 6, k <= 2, k == 8);
      end
    end
    en_wr1 = 1'b0; en_rd1 = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      tick();
      n_tests++;
      if ({count1, af1, ae1, empty1} !== {4'(k), k >= 6, k <= 2, k == 0}) begin
        n_fail++;
        $display("FAIL thr_drain k=%0d act=%0d/%b%b%b exp=%0d/%b%b%b", k, count1, af1, ae1, empty1,
                 k, k >= 6, k <= 2, k == 0);
      end
    end
    idle();
  endtask

  task automatic test_random();
    int wp, rp;
    logic [17:0] act0, exp0;
    logic [10:0] act1, exp1;
    for (int c = 0; c < 600; c++) begin
      case ((c / 40) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      reset  = ($urandom_range(0, 99) == 0);
      en_wr0 = ($urandom_range(0, 99) < wp); en_rd0 = ($urandom_range(0, 99) < rp);
      en_wr1 = ($urandom_range(0, 99) < wp); en_rd1 = ($urandom_range(0, 99) < rp);
      clr0   = ($urandom_range(0, 15) == 0); clr1   = ($urandom_range(0, 15) == 0);
      din0   = 8'($urandom);                 din1   = 8'($urandom);
      tick();
      exp0 = {3'(q0.size()), q0.size() == 0, q0.size() == 5, q0.size() <= 1, q0.size() >= 4,
              m_rv0, m_ovf0, m_udf0, m_dout0};
      act0 = {count0, empty0, full0, ae0, af0, rv0, ovf0, udf0, dout0};
      n_tests++;
      if (act0 !== exp0) begin
        n_fail++; $display("FAIL rand0 cyc=%0d act=%h exp=%h", c, act0, exp0);
      end
      exp1 = {4'(q1.size()), q1.size() == 0, q1.size() == 8, q1.size() <= 2, q1.size() >= 6,
              q1.size() > 0, m_ovf1, m_udf1};
      act1 = {count1, empty1, full1, ae1, af1, rv1, ovf1, udf1};
      n_tests++;
      if (act1 !== exp1) begin
        n_fail++; $display("FAIL rand1 cyc=%0d act=%h exp=%h", c, act1, exp1);
      end
      if (q1.size() > 0) begin
        n_tests++;
        if (dout1 !== q1[0]) begin
          n_fail++; $display("FAIL rand1_dout cyc=%0d act=%h exp=%h", c, dout1, q1[0]);
        end
      end
    end
    reset = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_reset_mid();
    test_fwft();
    test_thresholds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
